// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_if
//  Description : Bus bundle between the accumulator CPU sequencer and its
//                instruction/data memories. The step line exists only when
//                CPU_SEQ_SINGLE_STEP_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_sequencer_if;
    logic        start;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_we;
    logic [15:0] dmem_rdata;
    logic [15:0] acc;
    logic [15:0] pc;
    logic        busy;
    logic        halted;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    logic        step;

    modport master (
        input  start, imem_data, dmem_rdata, step,
        output imem_addr, dmem_addr, dmem_wdata, dmem_we, acc, pc, busy, halted
    );

    modport slave (
        output start, imem_data, dmem_rdata, step,
        input  imem_addr, dmem_addr, dmem_wdata, dmem_we, acc, pc, busy, halted
    );
`else
    modport master (
        input  start, imem_data, dmem_rdata,
        output imem_addr, dmem_addr, dmem_wdata, dmem_we, acc, pc, busy, halted
    );

    modport slave (
        output start, imem_data, dmem_rdata,
        input  imem_addr, dmem_addr, dmem_wdata, dmem_we, acc, pc, busy, halted
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multicycle fetch/decode/execute sequencer for the accumulator
//                CPU. Optional macro CPU_SEQ_SINGLE_STEP_EN adds a STEP_WAIT
//                state released by the step input.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
    parameter logic [15:0] START_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXEC      = 3'd3,
        S_HALT      = 3'd4,
        S_STEP_WAIT = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;
`endif

    localparam logic [2:0] c_op_lda  = 3'b000;
    localparam logic [2:0] c_op_sta  = 3'b001;
    localparam logic [2:0] c_op_add  = 3'b010;
    localparam logic [2:0] c_op_sub  = 3'b011;
    localparam logic [2:0] c_op_jmp  = 3'b100;
    localparam logic [2:0] c_op_jez  = 3'b101;
    localparam logic [2:0] c_op_ldi  = 3'b110;
    localparam logic [2:0] c_op_halt = 3'b111;

    state_t      state_q, state_d;
    logic [15:0] pc_q,    pc_d;
    logic [15:0] ir_q,    ir_d;
    logic [15:0] acc_q,   acc_d;

    logic [2:0]  opcode;
    logic [15:0] operand;

    assign opcode  = ir_q[15:13];
    assign operand = {3'b000, ir_q[12:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            ir_q    <= 16'h0000;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = bus.imem_data;
                pc_d    = pc_q + 16'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (opcode == c_op_halt) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                // sta needs no register update; its write strobe is decoded below
                case (opcode)
                    c_op_lda: acc_d = bus.dmem_rdata;
                    c_op_add: acc_d = acc_q + bus.dmem_rdata;
                    c_op_sub: acc_d = acc_q - bus.dmem_rdata;
                    c_op_jmp: pc_d  = operand;
                    c_op_jez: begin
                        if (acc_q == 16'h0000) begin
                            pc_d = operand;
                        end
                    end
                    c_op_ldi: acc_d = operand;
                    default:  ;
                endcase
`ifdef CPU_SEQ_SINGLE_STEP_EN
                state_d = S_STEP_WAIT;
`else
                state_d = S_FETCH;
`endif
            end
`ifdef CPU_SEQ_SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (bus.step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.imem_addr  = pc_q;
    assign bus.dmem_addr  = operand;
    assign bus.dmem_wdata = acc_q;
    // rst gating keeps a reset landing on a sta EXEC cycle from writing memory
    assign bus.dmem_we    = (state_q == S_EXEC) && (opcode == c_op_sta) && !rst;
    assign bus.acc        = acc_q;
    assign bus.pc         = pc_q;
    assign bus.halted     = (state_q == S_HALT);
`ifdef CPU_SEQ_SINGLE_STEP_EN
    assign bus.busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                            (state_q == S_EXEC)  || (state_q == S_STEP_WAIT);
`else
    assign bus.busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                            (state_q == S_EXEC);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Directed self-checking bench for cpu_sequencer with a
//                scoreboard queue of expected observations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pre_en;
    logic [3:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] imem [0:15];
    logic [15:0] dmem [0:15];
    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;

    cpu_sequencer_if bus ();

    cpu_sequencer #(
        .START_PC (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data  = imem[bus.imem_addr[3:0]];
    assign bus.dmem_rdata = dmem[bus.dmem_addr[3:0]];

    always @(posedge clk) begin
        if (pre_en) begin
            dmem[pre_addr] <= pre_data;
        end else if (bus.dmem_we) begin
            dmem[bus.dmem_addr[3:0]] <= bus.dmem_wdata;
        end
    end

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        advance(1);
        pre_en   = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = 16'hE000;
    endtask

    task automatic begin_test();
        rst   = 1'b1;
        bus.start = 1'b0;
        advance(2);
        clear_imem();
    endtask

    // leaves the bench at the negedge inside the first FETCH cycle
    task automatic go();
        rst       = 1'b0;
        bus.start = 1'b1;
        advance(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        while (bus.halted !== 1'b1 && n < 60) begin
            advance(1);
            n++;
        end
        checks++;
        assert (bus.halted === 1'b1) else begin
            errors++;
            $error("FAIL %s_halt_timeout: observed=%b expected=1", tag, bus.halted);
        end
    endtask

    initial begin
        int we_n;
        int we_at;
        pre_en   = 1'b0;
        pre_addr = 4'h0;
        pre_data = 16'h0000;
`ifdef CPU_SEQ_SINGLE_STEP_EN
        bus.step = 1'b0;
`endif
        clear_imem();

        // Reset with start held high, then program C00A / 2000 / E000
        rst       = 1'b1;
        bus.start = 1'b1;
        expect_val("rst_pc", 16'h0000);
        expect_val("rst_acc", 16'h0000);
        expect_val("rst_busy", 16'h0000);
        expect_val("rst_halted", 16'h0000);
        expect_val("rst_dmem_we", 16'h0000);
        advance(2);
        check(bus.pc);
        check(bus.acc);
        check({15'd0, bus.busy});
        check({15'd0, bus.halted});
        check({15'd0, bus.dmem_we});

        imem[0] = 16'hC00A;
        imem[1] = 16'h2000;
        imem[2] = 16'hE000;
        expect_val("p1_fetch_busy", 16'h0001);
        expect_val("p1_fetch_addr", 16'h0000);
        expect_val("p1_halted_c8", 16'h0000);
        expect_val("p1_halted_c9", 16'h0001);
        expect_val("p1_pc", 16'h0003);
        expect_val("p1_we_count", 16'd1);
        expect_val("p1_we_cycle", 16'd6);
        expect_val("p1_dmem0", 16'h000A);
        expect_val("p1_busy_halt", 16'h0000);
        go();
        check({15'd0, bus.busy});
        check(bus.imem_addr);
        we_n  = 0;
        we_at = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) advance(1);
            if (bus.dmem_we === 1'b1) begin
                we_n++;
                we_at = c;
            end
            if (c == 8) check({15'd0, bus.halted});
        end
        check({15'd0, bus.halted});
        check(bus.pc);
        check(16'(we_n));
        check(16'(we_at));
        check(dmem[0]);
        check({15'd0, bus.busy});

        // HALT is sticky even with start held high
        expect_val("halt_sticky", 16'h0001);
        expect_val("halt_pc_hold", 16'h0003);
        bus.start = 1'b1;
        advance(5);
        check({15'd0, bus.halted});
        check(bus.pc);
        bus.start = 1'b0;

        // Accumulator wrap to zero, jez taken
        begin_test();
        imem[0] = 16'hC001;
        imem[1] = 16'h4001;
        imem[2] = 16'hA005;
        poke(4'd1, 16'hFFFF);
        expect_val("wrap_fetch_addr", 16'h0005);
        expect_val("wrap_acc", 16'h0000);
        expect_val("wrap_busy", 16'h0001);
        expect_val("wrap_halt_pc", 16'h0006);
        go();
        advance(9);
        check(bus.imem_addr);
        check(bus.acc);
        check({15'd0, bus.busy});
        wait_halt("wrap");
        check(bus.pc);

        // jez not taken
        begin_test();
        imem[0] = 16'hC002;
        imem[1] = 16'hA007;
        expect_val("jnt_fetch_addr", 16'h0002);
        expect_val("jnt_acc", 16'h0002);
        go();
        advance(6);
        check(bus.imem_addr);
        check(bus.acc);
        wait_halt("jnt");

        // sub underflow
        begin_test();
        imem[0] = 16'hC001;
        imem[1] = 16'h6000;
        poke(4'd0, 16'h0003);
        expect_val("sub_acc", 16'hFFFE);
        go();
        advance(6);
        check(bus.acc);
        wait_halt("sub");

        // lda, add, jmp
        begin_test();
        imem[0] = 16'h0002;
        imem[1] = 16'h4003;
        imem[2] = 16'h8007;
        imem[3] = 16'hC0FF;
        poke(4'd2, 16'h1111);
        poke(4'd3, 16'h2222);
        expect_val("lda_add_acc", 16'h3333);
        expect_val("jmp_halt_pc", 16'h0008);
        go();
        wait_halt("jmp");
        check(bus.acc);
        check(bus.pc);

        // Reset during the EXEC cycle of a sta
        begin_test();
        imem[0] = 16'hC055;
        imem[1] = 16'h2000;
        poke(4'd0, 16'h1234);
        expect_val("msta_we_exec", 16'h0001);
        expect_val("msta_wdata", 16'h0055);
        expect_val("msta_we_gated", 16'h0000);
        expect_val("msta_busy", 16'h0000);
        expect_val("msta_pc", 16'h0000);
        expect_val("msta_acc", 16'h0000);
        expect_val("msta_dmem0", 16'h1234);
        expect_val("msta_idle_busy", 16'h0000);
        expect_val("msta_idle_pc", 16'h0000);
        go();
        advance(5);
        check({15'd0, bus.dmem_we});
        check(bus.dmem_wdata);
        rst = 1'b1;
        #1;
        check({15'd0, bus.dmem_we});
        advance(1);
        check({15'd0, bus.busy});
        check(bus.pc);
        check(bus.acc);
        check(dmem[0]);
        rst = 1'b0;
        advance(3);
        check({15'd0, bus.busy});
        check(bus.pc);

`ifdef CPU_SEQ_SINGLE_STEP_EN
        // Single-step hold and release
        begin_test();
        imem[0] = 16'hC001;
        imem[1] = 16'hC002;
        go();
        advance(3);
        for (int k = 0; k < 10; k++) begin
            expect_val("step_hold_pc", 16'h0001);
            expect_val("step_hold_busy", 16'h0001);
            check(bus.pc);
            check({15'd0, bus.busy});
            advance(1);
        end
        expect_val("step_fetch_addr", 16'h0001);
        expect_val("step_fetch_pc", 16'h0002);
        bus.step = 1'b1;
        advance(1);
        bus.step = 1'b0;
        check(bus.imem_addr);
        advance(1);
        check(bus.pc);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer for the simple accumulator CPU. It owns the program counter, instruction register and accumulator. It fetches instruction words from the instruction memory over `imem_addr`/`imem_data`, decodes them, and sequences data-memory reads and writes. Each instruction takes one fetch, one decode and one execute cycle. The block sits between the asynchronous-read instruction memory and a data memory with the same read style.

## Interface
- `START_PC`, default 16'h0000, PC value loaded on reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled only in IDLE; begins execution at the current PC.
- `imem_addr`  out  16  instruction address (abus of instruction memory).
- `imem_data`  in  16  instruction word; combinational read of `imem_addr`.
- `dmem_addr`  out  16  data address, `{3'b000, ir[12:0]}`.
- `dmem_wdata`  out  16  equals `acc`.
- `dmem_we`  out  1  write strobe; data memory writes on the rising edge while high.
- `dmem_rdata`  in  16  combinational read of `dmem_addr`.
- `acc`  out  16  accumulator.
- `pc`  out  16  program counter.
- `busy`  out  1  high in FETCH/DECODE/EXEC (and STEP_WAIT if compiled).
- `halted`  out  1  high in HALT.
- `step`  in  1  present only with `CPU_SEQ_SINGLE_STEP_EN`.

## Operation
- Instruction format: opcode `ir[15:13]`, operand `ir[12:0]`, zero-extended to 16 bits.
- Opcode 000 lda: `acc <= dmem_rdata`.
- Opcode 001 sta: `dmem_we` is high for the EXEC cycle.
- Opcode 010 add: `acc <= acc + dmem_rdata`, mod 2^16.
- Opcode 011 sub: `acc <= acc - dmem_rdata`, mod 2^16.
- Opcode 100 jmp: `pc <= operand`.
- Opcode 101 jez: `pc <= operand` if `acc == 0`; otherwise no change.
- Opcode 110 ldi: `acc <= {3'b000, operand}`.
- Opcode 111 halt: go to HALT.
- No carry or overflow flags. The jez test uses `acc` as it stands at the start of EXEC.
- States and transitions:
  - IDLE → FETCH when `start` = 1.
  - FETCH: `imem_addr = pc`; `ir <= imem_data`; `pc <= pc + 1` (16-bit wrap, FFFF → 0000); → DECODE.
  - DECODE: holds `dmem_addr` stable; no register updates; → EXEC, or → HALT if opcode = 111.
  - EXEC: performs the opcode action; → FETCH.
  - HALT: sticky; only `rst` leaves it. `start` is ignored.
- `imem_addr` equals `pc` in every state.
- `dmem_we = (state == EXEC) && (opcode == 001) && !rst`. It is never high in any other state.
- Reset values: `pc` = START_PC, `ir` = 0, `acc` = 0, state = IDLE, `busy` = 0, `halted` = 0, `dmem_we` = 0.
- Reset mid-instruction:
  - The instruction is abandoned and no architectural update occurs on that edge.
  - A sta in EXEC does not write, because `dmem_we` is gated by `rst`.
- `start` held high after HALT has no effect. `start` pulses while busy are ignored.

## Timing
- Latency: 3 cycles per instruction.
- With `start` sampled high at edge 0:
  - first FETCH at cycle 1;
  - first EXEC update lands at edge 3;
  - the next FETCH is at cycle 4.
- A halt instruction: FETCH then DECODE; `halted` rises after the DECODE edge (2 cycles after its FETCH).
- `acc`, `pc` and `halted` are registered outputs.
- `dmem_addr`, `dmem_wdata` and `dmem_we` are combinational from registered state and `rst`.
- A jmp or jez target takes effect at the fetch immediately following its EXEC.

## Configuration
- `CPU_SEQ_SINGLE_STEP_EN` defined:
  - adds the `step` input and a STEP_WAIT state;
  - EXEC → STEP_WAIT instead of FETCH;
  - STEP_WAIT → FETCH on the first cycle with `step` = 1;
  - `busy` stays high in STEP_WAIT; reset clears to IDLE.
- Undefined:
  - no `step` port and no STEP_WAIT state;
  - EXEC → FETCH unconditionally.

## Test plan
- Reset: assert `rst` for 2 cycles with `start` = 1 → `pc` = 0, `acc` = 0, `busy` = 0, `halted` = 0, `dmem_we` = 0; FETCH begins 1 cycle after `rst` falls.
- Program C00A, 2000, E000:
  - `dmem[0]` = 000A after edge 6;
  - `dmem_we` high exactly one cycle (cycle 6);
  - `halted` = 1 after edge 8, with `pc` = 3.
- Wrap, with `dmem[1]` preloaded FFFF: program C001, 4001, A005 → `acc` = 0000, jez taken, next `imem_addr` = 0005.
- jez not taken: program C002, A007 → `acc` = 0002; next fetch address = 0002.
- sub underflow: `dmem[0]` = 0003, program C001, 6000 → `acc` = FFFE.
- Reset mid-sta: assert `rst` during the EXEC cycle of 2000 with `acc` = 0x55 → `dmem[0]` unchanged, state IDLE.
- With `CPU_SEQ_SINGLE_STEP_EN`:
  - after ldi completes, `pc` holds at 1 and `busy` = 1 for 10 cycles while `step` = 0;
  - a 1-cycle `step` pulse → next FETCH occurs the following cycle.
